// File: rtl/pixel_pkg.sv
// Shared encodings and constants for the streaming pixel processor.
// Geometry-dependent constants are derived per instance through the helper function.
package pixel_pkg;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_ADD    = 3'd1,
    MODE_SUB    = 3'd2,
    MODE_INV    = 3'd3,
    MODE_THRESH = 3'd4,
    MODE_GRAY   = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DW_DEF     = 8;
  localparam int LANES_DEF  = 2;
  localparam int WIDTH_DEF  = 768;
  localparam int HEIGHT_DEF = 512;

  function automatic int calc_frame_beats(input int width, input int height, input int lanes);
    return (width * height) / lanes;
  endfunction

  localparam int FRAME_BEATS = calc_frame_beats(WIDTH_DEF, HEIGHT_DEF, LANES_DEF);
  localparam int MAXVAL      = (1 << DW_DEF) - 1;

endpackage

// File: rtl/pixel_op.sv
// Combinational point operation on one RGB pixel; every lane uses an identical copy.
module pixel_op
  import pixel_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] r_i,
  input  logic [DW-1:0] g_i,
  input  logic [DW-1:0] b_i,
  input  logic [2:0]    mode_i,
  input  logic [DW-1:0] value_i,
  output logic [DW-1:0] r_o,
  output logic [DW-1:0] g_o,
  output logic [DW-1:0] b_o
);

  localparam logic [DW-1:0] MAX = '1;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] x, input logic [DW-1:0] v);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, v};
    return s[DW] ? MAX : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x, input logic [DW-1:0] v);
    return (x > v) ? (x - v) : '0;
  endfunction

  logic [DW+1:0] gray_sum;
  logic [DW-1:0] luma;
  logic [DW-1:0] thresh;

  // NOTE: every signal written here gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gray_sum = {2'b00, r_i} + {1'b0, g_i, 1'b0} + {2'b00, b_i};
    luma     = DW'(gray_sum >> 2);
    thresh   = (luma > value_i) ? MAX : '0;
    r_o      = r_i;
    g_o      = g_i;
    b_o      = b_i;
    case (mode_e'(mode_i))
      MODE_ADD: begin
        r_o = sat_add(r_i, value_i);
        g_o = sat_add(g_i, value_i);
        b_o = sat_add(b_i, value_i);
      end
      MODE_SUB: begin
        r_o = sat_sub(r_i, value_i);
        g_o = sat_sub(g_i, value_i);
        b_o = sat_sub(b_i, value_i);
      end
      MODE_INV: begin
        r_o = MAX - r_i;
        g_o = MAX - g_i;
        b_o = MAX - b_i;
      end
      MODE_THRESH: begin
        r_o = thresh;
        g_o = thresh;
        b_o = thresh;
      end
      MODE_GRAY: begin
        r_o = luma;
        g_o = luma;
        b_o = luma;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pixel_proc_pipe.sv
// Two-stage streaming pixel processor: stage 1 registers the beat, stage 2 the processed result.
// A small frame FSM latches MODE/VALUE on the first beat and flags the last beat at the output.
module pixel_proc_pipe
  import pixel_pkg::*;
#(
  parameter int DW       = 8,
  parameter int LANES    = 2,
  parameter int WIDTH    = 768,
  parameter int HEIGHT   = 512,
  parameter int PIXCNT_W = 20
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSYNC_IN,
  input  logic [LANES*DW-1:0] DATA_R_IN,
  input  logic [LANES*DW-1:0] DATA_G_IN,
  input  logic [LANES*DW-1:0] DATA_B_IN,
  input  logic [2:0]          MODE,
  input  logic [DW-1:0]       VALUE,
  output logic                HSYNC_OUT,
  output logic [LANES*DW-1:0] DATA_R_OUT,
  output logic [LANES*DW-1:0] DATA_G_OUT,
  output logic [LANES*DW-1:0] DATA_B_OUT,
  output logic [PIXCNT_W-1:0] BEAT_CNT,
  output logic                FRAME_DONE,
  output logic                BUSY
);

  localparam logic [PIXCNT_W-1:0] BEATS_PER_FRAME =
    PIXCNT_W'(calc_frame_beats(WIDTH, HEIGHT, LANES));

  state_e                state_q, state_d;
  logic [PIXCNT_W-1:0]   cnt_q, cnt_d;
  logic                  drain_q, drain_d;
  logic                  capture, last_beat;
  logic [2:0]            mode_q;
  logic [DW-1:0]         value_q;
  logic                  hs_s1_q, last_s1_q;
  logic [LANES*DW-1:0]   r_s1_q, g_s1_q, b_s1_q;
  logic [LANES*DW-1:0]   r_op, g_op, b_op;

  // A beat seen in IDLE or DRAIN opens a new frame; drain_q marks the second DRAIN cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    capture   = 1'b0;
    last_beat = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (HSYNC_IN) begin
          capture = 1'b1;
          cnt_d   = PIXCNT_W'(1);
        end
      end
      RUN: begin
        if (HSYNC_IN) cnt_d = cnt_q + PIXCNT_W'(1);
      end
      DRAIN: begin
        if (HSYNC_IN) begin
          capture = 1'b1;
          cnt_d   = PIXCNT_W'(1);
        end else if (!drain_q) begin
          drain_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (HSYNC_IN) begin
      state_d = RUN;
      drain_d = 1'b0;
      if (cnt_d == BEATS_PER_FRAME) begin
        state_d   = DRAIN;
        last_beat = 1'b1;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      mode_q     <= '0;
      value_q    <= '0;
      hs_s1_q    <= 1'b0;
      last_s1_q  <= 1'b0;
      r_s1_q     <= '0;
      g_s1_q     <= '0;
      b_s1_q     <= '0;
      HSYNC_OUT  <= 1'b0;
      FRAME_DONE <= 1'b0;
      DATA_R_OUT <= '0;
      DATA_G_OUT <= '0;
      DATA_B_OUT <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      if (capture) begin
        mode_q  <= MODE;
        value_q <= VALUE;
      end
      hs_s1_q    <= HSYNC_IN;
      last_s1_q  <= last_beat;
      r_s1_q     <= DATA_R_IN;
      g_s1_q     <= DATA_G_IN;
      b_s1_q     <= DATA_B_IN;
      HSYNC_OUT  <= hs_s1_q;
      FRAME_DONE <= last_s1_q;
      if (hs_s1_q) begin
        DATA_R_OUT <= r_op;
        DATA_G_OUT <= g_op;
        DATA_B_OUT <= b_op;
      end
    end
  end

  // The mode register updates on the same edge the first beat enters stage 1, so that beat already sees it.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pixel_op #(.DW(DW)) u_op (
      .r_i     (r_s1_q[k*DW +: DW]),
      .g_i     (g_s1_q[k*DW +: DW]),
      .b_i     (b_s1_q[k*DW +: DW]),
      .mode_i  (mode_q),
      .value_i (value_q),
      .r_o     (r_op[k*DW +: DW]),
      .g_o     (g_op[k*DW +: DW]),
      .b_o     (b_op[k*DW +: DW])
    );
  end

  assign BEAT_CNT = cnt_q;
  assign BUSY     = (state_q == RUN) || (state_q == DRAIN);

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Directed bench for pixel_proc_pipe with an 8x2 image, 2 lanes of 8-bit RGB (8 beats per frame).
module tb_pixel_proc_pipe;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSYNC_IN;
  logic [15:0] DATA_R_IN, DATA_G_IN, DATA_B_IN;
  logic [2:0]  MODE;
  logic [7:0]  VALUE;
  logic        HSYNC_OUT;
  logic [15:0] DATA_R_OUT, DATA_G_OUT, DATA_B_OUT;
  logic [19:0] BEAT_CNT;
  logic        FRAME_DONE;
  logic        BUSY;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  val;
    logic [15:0] r, g, b, er, eg, eb;
  } op_vec_t;

  pixel_proc_pipe #(.DW(8), .LANES(2), .WIDTH(8), .HEIGHT(2), .PIXCNT_W(20)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSYNC_IN   (HSYNC_IN),
    .DATA_R_IN  (DATA_R_IN),
    .DATA_G_IN  (DATA_G_IN),
    .DATA_B_IN  (DATA_B_IN),
    .MODE       (MODE),
    .VALUE      (VALUE),
    .HSYNC_OUT  (HSYNC_OUT),
    .DATA_R_OUT (DATA_R_OUT),
    .DATA_G_OUT (DATA_G_OUT),
    .DATA_B_OUT (DATA_B_OUT),
    .BEAT_CNT   (BEAT_CNT),
    .FRAME_DONE (FRAME_DONE),
    .BUSY       (BUSY)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [7:0] add_sat(input int x, input int v);
    return (x + v > 255) ? 8'd255 : 8'(x + v);
  endfunction

  task automatic test_reset();
    HRESET = 1'b1; HSYNC_IN = 1'b0; MODE = 3'd0; VALUE = 8'd0;
    DATA_R_IN = '0; DATA_G_IN = '0; DATA_B_IN = '0;
    tick(); tick();
    n_checks++;
    if ({HSYNC_OUT, FRAME_DONE, BUSY, BEAT_CNT, DATA_R_OUT, DATA_G_OUT, DATA_B_OUT} !== '0) begin
      n_fails++;
      $display("FAIL reset_initial: ctrl=%b cnt=%0d data=%h/%h/%h, want all zero",
               {HSYNC_OUT, FRAME_DONE, BUSY}, BEAT_CNT, DATA_R_OUT, DATA_G_OUT, DATA_B_OUT);
    end
    HRESET = 1'b0;
    // Partial frame in invert mode so the outputs are visibly non-zero before the abort.
    MODE = 3'd3;
    for (int j = 0; j < 5; j++) begin
      HSYNC_IN = 1'b1;
      tick();
    end
    n_checks++;
    if (BEAT_CNT !== 20'd5 || BUSY !== 1'b1 || DATA_R_OUT !== 16'hffff) begin
      n_fails++;
      $display("FAIL reset_prefill: cnt=%0d busy=%b r=%h, want 5 1 ffff", BEAT_CNT, BUSY, DATA_R_OUT);
    end
    HRESET = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      n_checks++;
      if ({HSYNC_OUT, FRAME_DONE, BUSY, BEAT_CNT, DATA_R_OUT, DATA_G_OUT, DATA_B_OUT} !== '0) begin
        n_fails++;
        $display("FAIL reset_mid%0d: ctrl=%b cnt=%0d data=%h/%h/%h, want all zero",
                 j, {HSYNC_OUT, FRAME_DONE, BUSY}, BEAT_CNT, DATA_R_OUT, DATA_G_OUT, DATA_B_OUT);
      end
    end
    HRESET = 1'b0; HSYNC_IN = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++;
      if ({HSYNC_OUT, FRAME_DONE, BUSY, BEAT_CNT} !== '0) begin
        n_fails++;
        $display("FAIL reset_after%0d: ctrl=%b cnt=%0d, want 000 0", j, {HSYNC_OUT, FRAME_DONE, BUSY}, BEAT_CNT);
      end
    end
    // Fresh frame in pass mode counts from 1 and completes normally.
    MODE = 3'd0;
    DATA_R_IN = 16'h1234; DATA_G_IN = 16'h5678; DATA_B_IN = 16'h9abc;
    for (int j = 0; j < 10; j++) begin
      HSYNC_IN = (j < 8);
      tick();
      n_checks++;
      if (BEAT_CNT !== ((j <= 7) ? 20'(j + 1) : 20'd0)) begin
        n_fails++;
        $display("FAIL reset_newframe_cnt%0d: got %0d want %0d", j, BEAT_CNT, (j <= 7) ? j + 1 : 0);
      end
      n_checks++;
      if ({HSYNC_OUT, FRAME_DONE} !== {j >= 1 && j <= 8, j == 8}) begin
        n_fails++;
        $display("FAIL reset_newframe_ctrl%0d: got %b want %b", j, {HSYNC_OUT, FRAME_DONE}, {j >= 1 && j <= 8, j == 8});
      end
    end
    n_checks++;
    if ({DATA_R_OUT, DATA_G_OUT, DATA_B_OUT} !== {16'h1234, 16'h5678, 16'h9abc}) begin
      n_fails++;
      $display("FAIL reset_newframe_pass: got %h/%h/%h want 1234/5678/9abc", DATA_R_OUT, DATA_G_OUT, DATA_B_OUT);
    end
  endtask

  task automatic test_point_ops();
    op_vec_t v [8];
    // Lane 1 in the upper byte, lane 0 in the lower byte.
    v[0] = '{3'd1, 8'd200, {8'd10, 8'd100}, {8'd55, 8'd55}, {8'd56, 8'd0},
             {8'd210, 8'd255}, {8'd255, 8'd255}, {8'd255, 8'd200}};
    v[1] = '{3'd2, 8'd30, {8'd255, 8'd20}, {8'd100, 8'd30}, {8'd0, 8'd31},
             {8'd225, 8'd0}, {8'd70, 8'd0}, {8'd0, 8'd1}};
    v[2] = '{3'd3, 8'd0, {8'd1, 8'd0}, {8'd2, 8'd255}, {8'd3, 8'd128},
             {8'd254, 8'd255}, {8'd253, 8'd0}, {8'd252, 8'd127}};
    v[3] = '{3'd5, 8'd0, {8'd255, 8'd100}, {8'd255, 8'd50}, {8'd255, 8'd10},
             {8'd255, 8'd52}, {8'd255, 8'd52}, {8'd255, 8'd52}};
    v[4] = '{3'd4, 8'd52, {8'd255, 8'd100}, {8'd255, 8'd50}, {8'd255, 8'd10},
             {8'd255, 8'd0}, {8'd255, 8'd0}, {8'd255, 8'd0}};
    v[5] = '{3'd4, 8'd51, {8'd0, 8'd100}, {8'd0, 8'd50}, {8'd0, 8'd10},
             {8'd0, 8'd255}, {8'd0, 8'd255}, {8'd0, 8'd255}};
    v[6] = '{3'd0, 8'd77, {8'd4, 8'd1}, {8'd5, 8'd2}, {8'd6, 8'd3},
             {8'd4, 8'd1}, {8'd5, 8'd2}, {8'd6, 8'd3}};
    v[7] = '{3'd7, 8'd99, {8'd200, 8'd9}, {8'd100, 8'd8}, {8'd50, 8'd7},
             {8'd200, 8'd9}, {8'd100, 8'd8}, {8'd50, 8'd7}};
    for (int n = 0; n < 8; n++) begin
      MODE = v[n].mode; VALUE = v[n].val;
      DATA_R_IN = v[n].r; DATA_G_IN = v[n].g; DATA_B_IN = v[n].b;
      for (int j = 0; j < 10; j++) begin
        HSYNC_IN = (j < 8);
        tick();
        n_checks++;
        if ({HSYNC_OUT, FRAME_DONE, BUSY} !== {j >= 1 && j <= 8, j == 8, j <= 8}) begin
          n_fails++;
          $display("FAIL ops%0d_ctrl%0d: hs/done/busy=%b want %b", n, j,
                   {HSYNC_OUT, FRAME_DONE, BUSY}, {j >= 1 && j <= 8, j == 8, j <= 8});
        end
        n_checks++;
        if (BEAT_CNT !== ((j <= 7) ? 20'(j + 1) : 20'd0)) begin
          n_fails++;
          $display("FAIL ops%0d_cnt%0d: got %0d want %0d", n, j, BEAT_CNT, (j <= 7) ? j + 1 : 0);
        end
        if (j >= 1) begin
          n_checks++;
          if ({DATA_R_OUT, DATA_G_OUT, DATA_B_OUT} !== {v[n].er, v[n].eg, v[n].eb}) begin
            n_fails++;
            $display("FAIL ops%0d_data%0d: got %h/%h/%h want %h/%h/%h", n, j,
                     DATA_R_OUT, DATA_G_OUT, DATA_B_OUT, v[n].er, v[n].eg, v[n].eb);
          end
        end
      end
    end
  endtask

  task automatic test_frame_count();
    logic [0:20] sched;
    logic [47:0] pix_prev, pix_now, exp_data;
    logic        hs_prev;
    int          beats;
    bit          have_out;
    sched    = 21'b100101100011010010000;
    beats    = 0;
    hs_prev  = 1'b0;
    pix_prev = '0;
    exp_data = '0;
    have_out = 0;
    MODE = 3'd0; VALUE = 8'd0;
    for (int j = 0; j < 21; j++) begin
      HSYNC_IN = sched[j];
      pix_now  = {8'(beats + 100), 8'(beats), 8'(beats * 3), 8'(beats + 50), 8'(255 - beats), 8'(beats * 7)};
      DATA_R_IN = pix_now[47:32]; DATA_G_IN = pix_now[31:16]; DATA_B_IN = pix_now[15:0];
      if (sched[j]) beats++;
      tick();
      if (hs_prev) begin
        exp_data = pix_prev;
        have_out = 1;
      end
      n_checks++;
      if ({HSYNC_OUT, FRAME_DONE, BUSY} !== {hs_prev, j == 17, j <= 17}) begin
        n_fails++;
        $display("FAIL frame_ctrl%0d: hs/done/busy=%b want %b", j, {HSYNC_OUT, FRAME_DONE, BUSY}, {hs_prev, j == 17, j <= 17});
      end
      n_checks++;
      if (BEAT_CNT !== ((j <= 16) ? 20'(beats) : 20'd0)) begin
        n_fails++;
        $display("FAIL frame_cnt%0d: got %0d want %0d", j, BEAT_CNT, (j <= 16) ? beats : 0);
      end
      if (have_out) begin
        n_checks++;
        if ({DATA_R_OUT, DATA_G_OUT, DATA_B_OUT} !== exp_data) begin
          n_fails++;
          $display("FAIL frame_data%0d: got %h%h%h want %h", j, DATA_R_OUT, DATA_G_OUT, DATA_B_OUT, exp_data);
        end
      end
      hs_prev  = sched[j];
      pix_prev = pix_now;
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp_data;
    int          k;
    for (int j = 0; j < 20; j++) begin
      // Mode changes from beat 3 on; frame 1 must ignore it, frame 2 (beat 8, in DRAIN) must use it.
      MODE  = (j < 3) ? 3'd1 : 3'd3;
      VALUE = (j < 3) ? 8'd10 : 8'd77;
      HSYNC_IN  = (j < 16);
      DATA_R_IN = {8'd250, 8'(j * 10)};
      DATA_G_IN = {8'(j), 8'(j * 10 + 1)};
      DATA_B_IN = {8'(255 - j), 8'd200};
      tick();
      n_checks++;
      if ({HSYNC_OUT, FRAME_DONE, BUSY} !== {j >= 1 && j <= 16, j == 8 || j == 16, j <= 16}) begin
        n_fails++;
        $display("FAIL b2b_ctrl%0d: hs/done/busy=%b want %b", j,
                 {HSYNC_OUT, FRAME_DONE, BUSY}, {j >= 1 && j <= 16, j == 8 || j == 16, j <= 16});
      end
      n_checks++;
      if (BEAT_CNT !== ((j <= 7) ? 20'(j + 1) : (j <= 15) ? 20'(j - 7) : 20'd0)) begin
        n_fails++;
        $display("FAIL b2b_cnt%0d: got %0d want %0d", j, BEAT_CNT, (j <= 7) ? j + 1 : (j <= 15) ? j - 7 : 0);
      end
      if (j >= 1 && j <= 16) begin
        k = j - 1;
        if (k < 8)
          exp_data = {8'd255, add_sat(k * 10, 10), add_sat(k, 10), add_sat(k * 10 + 1, 10),
                      add_sat(255 - k, 10), 8'd210};
        else
          exp_data = {8'd5, 8'(255 - k * 10), 8'(255 - k), 8'(254 - k * 10), 8'(k), 8'd55};
        n_checks++;
        if ({DATA_R_OUT, DATA_G_OUT, DATA_B_OUT} !== exp_data) begin
          n_fails++;
          $display("FAIL b2b_data%0d: got %h%h%h want %h", j, DATA_R_OUT, DATA_G_OUT, DATA_B_OUT, exp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_point_ops();
    test_frame_count();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pixel_proc_pipe.md
Name: pixel_proc_pipe

Overview:
Parametrised streaming pixel processor placed between image_read and image_write. It generalises the fixed two-pixels-per-clock, 8-bit RGB stream to LANES pixels per beat of DW bits per channel. It applies a run-time selectable point operation to every pixel: pass, brightness add, brightness subtract, invert, threshold or grayscale. It delays HSYNC to stay aligned with the data and flags the end of each frame.

Parameters:
DW, 8, bits per colour channel
LANES, 2, pixels per beat (1..8)
WIDTH, 768, image width in pixels (multiple of LANES)
HEIGHT, 512, image height in lines
PIXCNT_W, 20, pixel-beat counter width (must hold WIDTH*HEIGHT/LANES)

Ports:
HCLK  in  1  clock, all logic rising-edge
HRESET  in  1  synchronous active-high reset
HSYNC_IN  in  1  beat-valid: DATA_*_IN valid this cycle
DATA_R_IN  in  LANES*DW  red, lane k at [k*DW +: DW]
DATA_G_IN  in  LANES*DW  green, same packing
DATA_B_IN  in  LANES*DW  blue, same packing
MODE  in  3  0 pass, 1 add, 2 sub, 3 invert, 4 threshold, 5 gray; 6/7 treated as pass
VALUE  in  DW  operand for add/sub/threshold
HSYNC_OUT  out  1  HSYNC_IN delayed 2 cycles
DATA_R_OUT  out  LANES*DW  processed red
DATA_G_OUT  out  LANES*DW  processed green
DATA_B_OUT  out  LANES*DW  processed blue
BEAT_CNT  out  PIXCNT_W  beats accepted in current frame
FRAME_DONE  out  1  one-cycle pulse with the output of the last beat of a frame
BUSY  out  1  high in RUN and DRAIN

Behaviour:
- Reset, synchronous with HRESET=1 sampled at a clock edge: all outputs 0, state IDLE, mode register 0, value register 0, pipeline cleared. Reset mid-frame aborts the frame. No FRAME_DONE is produced for an aborted frame.
- Latency: 2 cycles. Stage 1 registers inputs and HSYNC. Stage 2 registers the computed result. HSYNC_OUT(t) = HSYNC_IN(t-2). DATA_*_OUT holds its last value when HSYNC_OUT=0.
- Mode capture: MODE/VALUE are latched only on the first beat of a frame (IDLE and HSYNC_IN=1). They are held for the whole frame. Changes mid-frame take effect at the next frame.
- Per-channel ops, unsigned DW-bit, identical on every lane:
  - add: min(x+VALUE, 2^DW-1), computed in DW+1 bits
  - sub: max(x-VALUE, 0)
  - invert: (2^DW-1)-x
  - gray: y=(R+2G+B)>>2, computed in DW+2 bits; R=G=B=y
  - threshold: y as for gray; all channels = 2^DW-1 if y>VALUE else 0 (y==VALUE gives 0)
- FSM:
  - IDLE: on HSYNC_IN=1, capture mode and set BEAT_CNT=1. Go to RUN, or to DRAIN directly if the frame is 1 beat.
  - RUN: each HSYNC_IN=1 increments BEAT_CNT. Gaps (HSYNC_IN=0) are allowed with no timeout. When the beat that makes BEAT_CNT = WIDTH*HEIGHT/LANES is accepted, go to DRAIN.
  - DRAIN: 2 cycles. FRAME_DONE pulses when the last beat appears on the outputs (2 cycles after acceptance). The next cycle goes to IDLE, with BEAT_CNT cleared to 0 in the same cycle FRAME_DONE is high.
  - HSYNC_IN=1 during DRAIN is the first beat of the next frame: it is processed with the NEW MODE/VALUE, and the FSM goes to RUN with BEAT_CNT=1. Back-to-back frames therefore need no idle gap. FRAME_DONE of the old frame still fires.
- BEAT_CNT never exceeds WIDTH*HEIGHT/LANES. It wraps to 0 only via frame completion or reset.
- No back-pressure: the downstream consumer must accept one beat per HSYNC_OUT.

Decomposition:
- Shared package pixel_pkg holds:
  - MODE encodings (MODE_PASS..MODE_GRAY)
  - the state enum (IDLE, RUN, DRAIN)
  - the constant FRAME_BEATS = WIDTH*HEIGHT/LANES
  - the DW-derived MAXVAL
- Sub-module pixel_op is natural: purely combinational, one pixel (R,G,B,mode,value) in and one pixel out. pixel_proc_pipe instantiates it LANES times in a generate loop between stage 1 and stage 2.

Test Plan:
- Reset: assert HRESET for 2 cycles mid-stream at BEAT_CNT=100 -> all outputs 0, BEAT_CNT=0, no FRAME_DONE. A new frame then counts from 1.
- Saturating add: DW=8, MODE=1, VALUE=200, pixel R=100,G=55,B=0 -> R=255,G=255,B=200, appearing exactly 2 cycles after input with HSYNC_OUT=1.
- Sub and invert: MODE=2, VALUE=30, R=20,G=30,B=31 -> 0,0,1. MODE=3 on R=0,G=255,B=128 -> 255,0,127.
- Gray/threshold: R=100,G=50,B=10 -> gray 52 on all channels. Threshold VALUE=52 -> 0,0,0. VALUE=51 -> 255,255,255.
- Frame count: WIDTH=8, HEIGHT=2, LANES=2, 8 beats with random gaps -> FRAME_DONE single pulse coincident with the 8th HSYNC_OUT. BEAT_CNT reaches 8, then 0. BUSY low afterwards.
- Mid-frame mode change plus back-to-back frames: switch MODE at beat 3, start frame 2 in the DRAIN cycle -> frame 1 uses the old mode throughout, frame 2 uses the new mode, and both FRAME_DONE pulses occur.
